// File: rtl/objects_pkg.sv
// Shared object codes and frame-tracking FSM states for the draw arbiter and RGB mux.
package objects_pkg;

  localparam int unsigned OBJ_W = 8;

  localparam logic [OBJ_W-1:0] OBJ_BACKGROUND = 8'h00;
  localparam logic [OBJ_W-1:0] OBJ_FROG       = 8'h01;
  localparam logic [OBJ_W-1:0] OBJ_WATERFALL  = 8'h03;
  localparam logic [OBJ_W-1:0] OBJ_LOG        = 8'h04;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACCUM      = 2'd1,
    DECIDE     = 2'd2
  } frame_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and parallel load.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over load, load wins over increment; the count sticks at max.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/objects_draw_arbiter.sv
// Per-pixel object priority select plus per-frame frog/log and frog/water overlap
// accounting that reports log riding and drowning once per completed frame.
module objects_draw_arbiter
  import objects_pkg::*;
#(
  parameter int unsigned DROWN_THRESHOLD = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             pixel_valid,
  input  logic             startOfFrame,
  input  logic             frog_drawing_request,
  input  logic             log_drawing_request,
  input  logic             waterfall_drawing_request,
  output logic [OBJ_W-1:0] object_to_draw,
  output logic             frog_on_log,
  output logic             frog_drown
);

  frame_state_t     state;
  frame_state_t     state_next;
  logic             log_hit_c;
  logic             water_hit_c;
  logic             cnt_clr_c;
  logic             cnt_load_c;
  logic             cnt_en_c;
  logic             snap_c;
  logic             decide_c;
  logic [OBJ_W-1:0] object_next_c;
  logic [CNT_W-1:0] log_cnt;
  logic [CNT_W-1:0] water_cnt;
  logic [CNT_W-1:0] log_snap;
  logic [CNT_W-1:0] water_snap;

  assign log_hit_c   = pixel_valid & frog_drawing_request & log_drawing_request;
  assign water_hit_c = pixel_valid & frog_drawing_request & waterfall_drawing_request
                       & ~log_drawing_request;

  // Priority select: frog over log over water; blanking forces background.
  always_comb begin
    object_next_c = OBJ_BACKGROUND;
    if (pixel_valid) begin
      if (frog_drawing_request)           object_next_c = OBJ_FROG;
      else if (log_drawing_request)       object_next_c = OBJ_LOG;
      else if (waterfall_drawing_request) object_next_c = OBJ_WATERFALL;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) state <= WAIT_FRAME;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_FRAME: if (startOfFrame) state_next = ACCUM;
      ACCUM:      if (startOfFrame) state_next = DECIDE;
      DECIDE:     state_next = startOfFrame ? DECIDE : ACCUM;
      default:    state_next = WAIT_FRAME;
    endcase
  end

  // The frame-start pixel is the first pixel of the new frame, so counters load it.
  always_comb begin
    cnt_clr_c  = 1'b0;
    cnt_load_c = 1'b0;
    cnt_en_c   = 1'b0;
    snap_c     = 1'b0;
    decide_c   = 1'b0;
    case (state)
      WAIT_FRAME: begin
        cnt_load_c = startOfFrame;
        cnt_clr_c  = ~startOfFrame;
      end
      ACCUM: begin
        cnt_load_c = startOfFrame;
        snap_c     = startOfFrame;
        cnt_en_c   = ~startOfFrame;
      end
      DECIDE: begin
        cnt_load_c = startOfFrame;
        snap_c     = startOfFrame;
        cnt_en_c   = ~startOfFrame;
        decide_c   = 1'b1;
      end
      default: cnt_clr_c = 1'b1;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_log_cnt (
    .clk      (CLK),
    .rst_n    (RESETn),
    .clr      (cnt_clr_c),
    .load     (cnt_load_c),
    .load_val (CNT_W'(log_hit_c)),
    .en       (cnt_en_c & log_hit_c),
    .count    (log_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_water_cnt (
    .clk      (CLK),
    .rst_n    (RESETn),
    .clr      (cnt_clr_c),
    .load     (cnt_load_c),
    .load_val (CNT_W'(water_hit_c)),
    .en       (cnt_en_c & water_hit_c),
    .count    (water_cnt)
  );

  // Decision reads the snapshot before any same-cycle re-snapshot overwrites it.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      object_to_draw <= OBJ_BACKGROUND;
      frog_on_log    <= 1'b0;
      frog_drown     <= 1'b0;
      log_snap       <= '0;
      water_snap     <= '0;
    end else begin
      object_to_draw <= object_next_c;
      frog_drown     <= 1'b0;
      if (snap_c) begin
        log_snap   <= log_cnt;
        water_snap <= water_cnt;
      end
      if (decide_c) begin
        frog_on_log <= (log_snap != '0);
        frog_drown  <= (log_snap == '0) && (32'(water_snap) >= DROWN_THRESHOLD);
      end
    end
  end

endmodule

// File: tb/tb_objects_draw_arbiter.sv
// Randomized frame-level bench: two arbiters (default and narrow saturating counters)
// compared every cycle against a frame-accounting reference model.
module tb_objects_draw_arbiter;

  localparam int unsigned TH_A = 16;
  localparam int unsigned W_A  = 16;
  localparam int unsigned TH_B = 7;
  localparam int unsigned W_B  = 3;

  typedef struct packed {
    logic rn;
    logic pv;
    logic sof;
    logic f;
    logic l;
    logic w;
  } stim_t;

  typedef struct {
    int lc;
    int wc;
  } dec_t;

  logic       clk = 1'b0;
  logic       rstn, pv, sof, fr, lg, wf;
  logic [7:0] obj_a, obj_b;
  logic       fol_a, drn_a, fol_b, drn_b;
  logic [19:0] obs;

  int passed = 0;
  int total  = 0;

  // Reference model state: counts of the currently open frame, decisions in flight.
  bit         in_frame;
  int         lc, wc;
  dec_t       pend[$];
  logic [7:0] e_obj;
  logic       e_fol_a, e_drn_a, e_fol_b, e_drn_b;

  stim_t stim[$];

  always #5 clk = ~clk;

  assign obs = {obj_a, fol_a, drn_a, obj_b, fol_b, drn_b};

  objects_draw_arbiter #(.DROWN_THRESHOLD(TH_A), .CNT_W(W_A)) dut_a (
    .CLK                       (clk),
    .RESETn                    (rstn),
    .pixel_valid               (pv),
    .startOfFrame              (sof),
    .frog_drawing_request      (fr),
    .log_drawing_request       (lg),
    .waterfall_drawing_request (wf),
    .object_to_draw            (obj_a),
    .frog_on_log               (fol_a),
    .frog_drown                (drn_a)
  );

  objects_draw_arbiter #(.DROWN_THRESHOLD(TH_B), .CNT_W(W_B)) dut_b (
    .CLK                       (clk),
    .RESETn                    (rstn),
    .pixel_valid               (pv),
    .startOfFrame              (sof),
    .frog_drawing_request      (fr),
    .log_drawing_request       (lg),
    .waterfall_drawing_request (wf),
    .object_to_draw            (obj_b),
    .frog_on_log               (fol_b),
    .frog_drown                (drn_b)
  );

  function automatic int sat(int x, int unsigned w);
    int m;
    m = (1 << w) - 1;
    return (x > m) ? m : x;
  endfunction

  function automatic logic [19:0] exp_vec();
    return {e_obj, e_fol_a, e_drn_a, e_obj, e_fol_b, e_drn_b};
  endfunction

  task automatic model_edge();
    int   cl, cw;
    dec_t d;
    cl = (pv && fr && lg) ? 1 : 0;
    cw = (pv && fr && wf && !lg) ? 1 : 0;
    if (!rstn) begin
      in_frame = 1'b0;
      lc = 0;
      wc = 0;
      pend.delete();
      e_obj = 8'h00;
      e_fol_a = 1'b0; e_drn_a = 1'b0; e_fol_b = 1'b0; e_drn_b = 1'b0;
      return;
    end
    if (!pv)     e_obj = 8'h00;
    else if (fr) e_obj = 8'h01;
    else if (lg) e_obj = 8'h04;
    else if (wf) e_obj = 8'h03;
    else         e_obj = 8'h00;
    e_drn_a = 1'b0;
    e_drn_b = 1'b0;
    if (pend.size() != 0) begin
      d = pend.pop_front();
      e_fol_a = (sat(d.lc, W_A) != 0);
      e_fol_b = (sat(d.lc, W_B) != 0);
      e_drn_a = (sat(d.lc, W_A) == 0) && (sat(d.wc, W_A) >= int'(TH_A));
      e_drn_b = (sat(d.lc, W_B) == 0) && (sat(d.wc, W_B) >= int'(TH_B));
    end
    if (sof) begin
      if (in_frame) begin
        d.lc = lc;
        d.wc = wc;
        pend.push_back(d);
      end
      in_frame = 1'b1;
      lc = cl;
      wc = cw;
    end else if (in_frame) begin
      lc += cl;
      wc += cw;
    end
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    rstn = s.rn; pv = s.pv; sof = s.sof; fr = s.f; lg = s.l; wf = s.w;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // sof_kind: 0 plain pixel, 1 frog+log, 2 frog+water on the frame-start pixel.
  task automatic add_frame(input int len, input int nwater, input int nlog, input int sof_kind);
    stim_t body[$];
    stim_t s, t;
    int    j;
    s = '{1'b1, 1'b1, 1'b1, 1'(sof_kind != 0), 1'(sof_kind == 1), 1'(sof_kind == 2)};
    stim.push_back(s);
    for (int i = 1; i < len; i++) begin
      if (i <= nwater)                  s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      else if (i <= nwater + nlog)      s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1))};
      else if ($urandom_range(0, 7) == 0) s = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      else s = '{1'b1, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      body.push_back(s);
    end
    for (int i = body.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = body[i];
      body[i] = body[j];
      body[j] = t;
    end
    foreach (body[k]) stim.push_back(body[k]);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) stim.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_reset();
    stim_t s;
    for (int i = 0; i < 4; i++)
      stim.push_back('{1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1});
    while (stim.size() != 0) begin
      s = stim.pop_front();
      drive(s);
      total++;
      if (obs !== exp_vec()) $display("FAIL reset got=%h exp=%h", obs, exp_vec());
      else passed++;
    end
  endtask

  task automatic test_priority();
    stim_t s;
    stim.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
    stim.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    stim.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    stim.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    stim.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 40; i++)
      stim.push_back('{1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
    while (stim.size() != 0) begin
      s = stim.pop_front();
      drive(s);
      total++;
      if (obs !== exp_vec()) $display("FAIL priority got=%h exp=%h", obs, exp_vec());
      else passed++;
    end
  endtask

  task automatic test_drown();
    stim_t s;
    int    i, npulse, pulse_at;
    i = 0; npulse = 0; pulse_at = -1;
    add_frame(30, 0, 0, 0);
    add_frame(40, 20, 0, 0);
    add_frame(10, 0, 0, 0);
    while (stim.size() != 0) begin
      s = stim.pop_front();
      drive(s);
      if (drn_a) begin npulse++; pulse_at = i; end
      total++;
      if (obs !== exp_vec()) $display("FAIL drown cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
      i++;
    end
    total++;
    if (npulse != 1 || pulse_at != 71)
      $display("FAIL drown_pulse count=%0d at=%0d exp count=1 at=71", npulse, pulse_at);
    else passed++;
  endtask

  task automatic test_threshold();
    stim_t s;
    int    i, npulse;
    bit    fol_ok;
    i = 0; npulse = 0; fol_ok = 1'b1;
    add_frame(40, 15, 0, 0);
    add_frame(120, 100, 1, 0);
    add_frame(20, 0, 0, 0);
    add_frame(10, 0, 0, 0);
    while (stim.size() != 0) begin
      s = stim.pop_front();
      drive(s);
      if (drn_a) npulse++;
      if (i >= 161 && i <= 180 && fol_a !== 1'b1) fol_ok = 1'b0;
      if (i == 181 && fol_a !== 1'b0) fol_ok = 1'b0;
      total++;
      if (obs !== exp_vec()) $display("FAIL threshold cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
      i++;
    end
    total++;
    if (npulse != 0 || !fol_ok)
      $display("FAIL threshold_summary pulses=%0d fol_ok=%0d exp pulses=0 fol_ok=1", npulse, fol_ok);
    else passed++;
  endtask

  task automatic test_sof_boundary();
    stim_t s;
    int    i;
    logic  fol21, fol41;
    i = 0; fol21 = 1'bx; fol41 = 1'bx;
    add_frame(20, 0, 0, 0);
    add_frame(20, 0, 0, 1);
    add_frame(10, 0, 0, 0);
    add_idle(3);
    while (stim.size() != 0) begin
      s = stim.pop_front();
      drive(s);
      if (i == 21) fol21 = fol_a;
      if (i == 41) fol41 = fol_a;
      total++;
      if (obs !== exp_vec()) $display("FAIL sof_boundary cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
      i++;
    end
    total++;
    if (fol21 !== 1'b0 || fol41 !== 1'b1)
      $display("FAIL sof_log_pixel fol@21=%b fol@41=%b exp 0 and 1", fol21, fol41);
    else passed++;
  endtask

  task automatic test_back_to_back();
    stim_t s;
    add_frame(1, 0, 0, 2);
    add_frame(1, 0, 0, 1);
    add_frame(1, 0, 0, 2);
    add_frame(1, 0, 0, 0);
    add_frame(6, 3, 0, 0);
    add_frame(1, 0, 0, 0);
    add_idle(4);
    while (stim.size() != 0) begin
      s = stim.pop_front();
      drive(s);
      total++;
      if (obs !== exp_vec()) $display("FAIL back_to_back got=%h exp=%h", obs, exp_vec());
      else passed++;
    end
  endtask

  task automatic test_random();
    stim_t s;
    int    len, nw, nl;
    for (int f = 0; f < 10; f++) begin
      len = int'($urandom_range(10, 50));
      nw  = int'($urandom_range(0, 24));
      if (nw > len - 2) nw = len - 2;
      nl  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      add_frame(len, nw, nl, int'($urandom_range(0, 2)));
    end
    add_idle(3);
    while (stim.size() != 0) begin
      s = stim.pop_front();
      drive(s);
      total++;
      if (obs !== exp_vec()) $display("FAIL random got=%h exp=%h", obs, exp_vec());
      else passed++;
    end
  endtask

  task automatic test_reset_midframe();
    stim_t s;
    int    i, npulse;
    logic [19:0] at_rst;
    i = 0; npulse = 0; at_rst = 'x;
    add_frame(60, 50, 0, 0);
    for (int k = 0; k < 3; k++) stim.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    add_idle(4);
    add_frame(10, 0, 0, 0);
    add_frame(10, 0, 0, 0);
    add_idle(4);
    while (stim.size() != 0) begin
      s = stim.pop_front();
      drive(s);
      if (i >= 60 && (drn_a || drn_b)) npulse++;
      if (i == 62) at_rst = obs;
      total++;
      if (obs !== exp_vec()) $display("FAIL reset_midframe cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      else passed++;
      i++;
    end
    total++;
    if (npulse != 0 || at_rst !== 20'h0)
      $display("FAIL reset_midframe_summary pulses=%0d outputs=%h exp 0 and 00000", npulse, at_rst);
    else passed++;
  endtask

  initial begin
    rstn = 1'b0; pv = 1'b0; sof = 1'b0; fr = 1'b0; lg = 1'b0; wf = 1'b0;
    in_frame = 1'b0; lc = 0; wc = 0;
    e_obj = 8'h00; e_fol_a = 1'b0; e_drn_a = 1'b0; e_fol_b = 1'b0; e_drn_b = 1'b0;
    test_reset();
    test_priority();
    test_drown();
    test_threshold();
    test_sof_boundary();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
